glyph_rom_arbiter: RTL and testbench

//  Shares one 1-bit-wide, synchronous glyph ROM (12-bit address, q registered on posedge) among
//  NUM_REQ display-overlay requesters. Requesters are served round-robin. For each granted request
//  the block reads ROW_W consecutive ROM bits and returns them as one packed pixel row with the

---
 rtl/glyph_rom_arbiter.sv | 169 ++++++++++++++++
 tb/tb_glyph_rom_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_rom_arbiter.sv
// glyph_rom_arbiter: round-robin arbiter sharing one 1-bit synchronous glyph ROM.
// Each grant fetches ROW_W consecutive ROM bits and returns them as a packed row
// (MSB = pixel at the start address) tagged with the requester ID.
// Optional feature macro: GLYPH_INV_EN adds req_inv (reverse-video row per request).
module glyph_rom_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned ROW_W   = 8,
  parameter int unsigned ID_W    = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
`ifdef GLYPH_INV_EN
  input  logic [NUM_REQ-1:0]        req_inv,
`endif
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic                      rom_q,
  output logic [ROW_W-1:0]          rd_data,
  output logic [ID_W-1:0]           rd_id,
  output logic                      rd_valid,
  output logic                      busy
);

  localparam int unsigned CNT_W = (ROW_W > 1) ? $clog2(ROW_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROW_W - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                inv_q, inv_d;
  logic [ROW_W-1:0]    shift_q, shift_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [ADDR_W-1:0]   rom_address_q, rom_address_d;
  logic [ROW_W-1:0]    rd_data_q, rd_data_d;
  logic [ID_W-1:0]     rd_id_q, rd_id_d;
  logic                rd_valid_q, rd_valid_d;

  logic                found;
  logic [ID_W-1:0]     win;
  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];

  // Unpack the flat request address bus into one entry per requester
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Round-robin search starting at the pointer; first pending request wins
  always_comb begin
    logic [ID_W-1:0] cand;
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = FETCH;
      FETCH:   if (cnt_q == CNT_LAST) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = found ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant, address sequencing and row capture.
  // rom_q lags rom_address by one cycle, so capture starts on the second FETCH
  // cycle and the last bit is taken in DRAIN.
  always_comb begin
    logic [ROW_W-1:0] row;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    id_d          = id_q;
    inv_d         = inv_q;
    shift_d       = shift_q;
    gnt_d         = '0;
    rom_address_d = rom_address_q;
    rd_data_d     = rd_data_q;
    rd_id_d       = rd_id_q;
    rd_valid_d    = 1'b0;
    row           = {shift_q[ROW_W-2:0], rom_q};
    case (state_q)
      IDLE, DONE: begin
        if (found) begin
          gnt_d         = NUM_REQ'(1) << win;
          rom_address_d = addr_arr[win];
          id_d          = win;
          cnt_d         = '0;
          ptr_d         = (32'(win) == NUM_REQ - 1) ? '0 : win + ID_W'(1);
`ifdef GLYPH_INV_EN
          inv_d         = req_inv[win];
`else
          inv_d         = 1'b0;
`endif
        end
      end
      FETCH: begin
        if (cnt_q != '0) shift_d = row;
        if (cnt_q != CNT_LAST) begin
          cnt_d         = cnt_q + 1'b1;
          rom_address_d = rom_address_q + 1'b1;
        end
      end
      DRAIN: begin
        rd_data_d  = inv_q ? ~row : row;
        rd_id_d    = id_q;
        rd_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q         <= '0;
      cnt_q         <= '0;
      id_q          <= '0;
      inv_q         <= 1'b0;
      shift_q       <= '0;
      gnt_q         <= '0;
      rom_address_q <= '0;
      rd_data_q     <= '0;
      rd_id_q       <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      id_q          <= id_d;
      inv_q         <= inv_d;
      shift_q       <= shift_d;
      gnt_q         <= gnt_d;
      rom_address_q <= rom_address_d;
      rd_data_q     <= rd_data_d;
      rd_id_q       <= rd_id_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  assign gnt         = gnt_q;
  assign rom_address = rom_address_q;
  assign rd_data     = rd_data_q;
  assign rd_id       = rd_id_q;
  assign rd_valid    = rd_valid_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_glyph_rom_arbiter.sv
// tb_glyph_rom_arbiter: directed and randomized checks of glyph_rom_arbiter
// against a behavioural model (ROM array, round-robin pick, expected rows).
module tb_glyph_rom_arbiter;
  localparam int NR = 4;
  localparam int AW = 12;
  localparam int RW = 8;
  localparam int IW = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic [NR-1:0]    req;
  logic [NR*AW-1:0] req_addr;
`ifdef GLYPH_INV_EN
  logic [NR-1:0]    req_inv;
`endif
  logic [NR-1:0]    gnt;
  logic [AW-1:0]    rom_address;
  logic             rom_q;
  logic [RW-1:0]    rd_data;
  logic [IW-1:0]    rd_id;
  logic             rd_valid;
  logic             busy;

  bit rom [4096];
  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_gnt2 = 0;
  int exp_start = 0;

  glyph_rom_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .ROW_W(RW), .ID_W(IW)) dut (
    .clock(clock), .reset(reset), .req(req), .req_addr(req_addr),
`ifdef GLYPH_INV_EN
    .req_inv(req_inv),
`endif
    .gnt(gnt), .rom_address(rom_address), .rom_q(rom_q), .rd_data(rd_data),
    .rd_id(rd_id), .rd_valid(rd_valid), .busy(busy)
  );

  always #5 clock = ~clock;

  // Synchronous 1-bit ROM: q registered on posedge
  always @(posedge clock) rom_q <= rom[rom_address];

  always @(negedge clock) begin
    if (rd_valid === 1'b1) n_valid++;
    if (gnt[2] === 1'b1) n_gnt2++;
  end

  function automatic int pick(input logic [NR-1:0] m, input int start);
    for (int i = 0; i < NR; i++) if (m[(start + i) % NR]) return (start + i) % NR;
    return -1;
  endfunction

  function automatic logic [RW-1:0] exp_row(input int base, input bit inv);
    logic [RW-1:0] r;
    for (int k = 0; k < RW; k++) r[RW-1-k] = rom[(base + k) % 4096];
    return inv ? ~r : r;
  endfunction

  function automatic logic [RW*AW-1:0] exp_addrs(input int base);
    logic [RW*AW-1:0] v;
    for (int k = 0; k < RW; k++) v[k*AW +: AW] = AW'((base + k) % 4096);
    return v;
  endfunction

  task automatic do_reset();
    req = '0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_start = 0;
  endtask

  // Observe one transaction: grant, address sequence, result. Drops the granted req.
  task automatic collect(output bit got, output logic [NR-1:0] g, output int wait_c,
                         output logic [RW*AW-1:0] addrs, output int lat,
                         output logic [RW-1:0] data, output logic [IW-1:0] id);
    got = 1'b0; g = '0; wait_c = 0; addrs = '0; lat = -1; data = '0; id = '0;
    while (!got && wait_c < 40) begin
      @(negedge clock);
      wait_c++;
      if (gnt !== '0) got = 1'b1;
    end
    if (!got) return;
    g = gnt;
    req = req & ~gnt;
    addrs[0 +: AW] = rom_address;
    for (int k = 1; k < RW; k++) begin
      @(negedge clock);
      addrs[k*AW +: AW] = rom_address;
    end
    for (int c = RW; c < RW + 20; c++) begin
      @(negedge clock);
      if (rd_valid === 1'b1) begin
        lat = c; data = rd_data; id = rd_id;
        break;
      end
    end
  endtask

  task automatic test_reset();
    req = '0;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++; if (rom_address !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 000", rom_address); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 00", rd_data); end
    checks++; if (rd_id !== '0) begin errors++; $display("FAIL reset_id: got %0d expected 0", rd_id); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rd_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    exp_start = 0;
  endtask

  task automatic test_single();
    bit got; logic [NR-1:0] g; int w, lat; logic [RW*AW-1:0] a; logic [RW-1:0] d; logic [IW-1:0] id;
    do_reset();
    req_addr[0 +: AW] = 12'd48;
    req = 4'b0001;
    collect(got, g, w, a, lat, d, id);
    checks++; if (g !== 4'b0001 || w != 1) begin errors++; $display("FAIL single_gnt: got %b after %0d cycles expected 0001 after 1", g, w); end
    checks++; if (a !== exp_addrs(48)) begin errors++; $display("FAIL single_addrs: got %h expected %h", a, exp_addrs(48)); end
    checks++; if (lat != RW + 1) begin errors++; $display("FAIL single_latency: got %0d expected %0d", lat, RW + 1); end
    checks++; if (d !== 8'h7C) begin errors++; $display("FAIL single_data: got %h expected 7c", d); end
    checks++; if (id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d expected 0", id); end
  endtask

  task automatic test_round_robin();
    bit got; logic [NR-1:0] g; int w, lat; logic [RW*AW-1:0] a; logic [RW-1:0] d; logic [IW-1:0] id;
    int bases [NR];
    logic [RW-1:0] rows [NR];
    bases = '{0, 120, 144, 48};
    rows  = '{8'h00, 8'h7E, 8'h48, 8'h7C};
    do_reset();
    for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = AW'(bases[i]);
    req = 4'b1111;
    for (int t = 0; t < NR; t++) begin
      collect(got, g, w, a, lat, d, id);
      checks++; if (g !== NR'(1 << t) || w != 1) begin errors++; $display("FAIL rr_gnt%0d: got %b after %0d cycles expected %b after 1", t, g, w, NR'(1 << t)); end
      checks++; if (a !== exp_addrs(bases[t])) begin errors++; $display("FAIL rr_addrs%0d: got %h expected %h", t, a, exp_addrs(bases[t])); end
      checks++; if (lat != RW + 1) begin errors++; $display("FAIL rr_latency%0d: got %0d expected %0d", t, lat, RW + 1); end
      checks++; if (d !== rows[t] || id !== IW'(t)) begin errors++; $display("FAIL rr_result%0d: got %h/id %0d expected %h/id %0d", t, d, id, rows[t], t); end
    end
  endtask

  task automatic test_busy_ignored();
    bit got; logic [NR-1:0] g; int w, lat; logic [RW*AW-1:0] a; logic [RW-1:0] d; logic [IW-1:0] id;
    int v0, g0;
    do_reset();
    req_addr[0 +: AW] = 12'd48;
    req_addr[2*AW +: AW] = 12'd144;
    v0 = n_valid; g0 = n_gnt2;
    req = 4'b0001;
    fork
      collect(got, g, w, a, lat, d, id);
      begin
        repeat (4) @(negedge clock);
        req[2] = 1'b1;
        @(negedge clock);
        req[2] = 1'b0;
      end
    join
    repeat (15) @(negedge clock);
    checks++; if (g !== 4'b0001 || d !== 8'h7C) begin errors++; $display("FAIL busy_txn: got %b/%h expected 0001/7c", g, d); end
    checks++; if (n_gnt2 != g0) begin errors++; $display("FAIL busy_gnt2: got %0d grants expected %0d", n_gnt2 - g0, 0); end
    checks++; if (n_valid != v0 + 1) begin errors++; $display("FAIL busy_valid_count: got %0d expected 1", n_valid - v0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_idle: got %b expected 0", busy); end
    checks++; if (rd_data !== 8'h7C || rd_id !== 2'd0) begin errors++; $display("FAIL busy_hold: got %h/id %0d expected 7c/id 0", rd_data, rd_id); end
  endtask

  task automatic test_wrap();
    bit got; logic [NR-1:0] g; int w, lat; logic [RW*AW-1:0] a; logic [RW-1:0] d; logic [IW-1:0] id;
    do_reset();
    req_addr[1*AW +: AW] = 12'd4092;
    req = 4'b0010;
    collect(got, g, w, a, lat, d, id);
    checks++; if (g !== 4'b0010) begin errors++; $display("FAIL wrap_gnt: got %b expected 0010", g); end
    checks++; if (a !== exp_addrs(4092)) begin errors++; $display("FAIL wrap_addrs: got %h expected %h", a, exp_addrs(4092)); end
    checks++; if (d !== 8'h00 || id !== 2'd1 || lat != RW + 1) begin errors++; $display("FAIL wrap_result: got %h/id %0d/lat %0d expected 00/id 1/lat %0d", d, id, lat, RW + 1); end
  endtask

  task automatic test_reset_abort();
    bit got; logic [NR-1:0] g; int w, lat; logic [RW*AW-1:0] a; logic [RW-1:0] d; logic [IW-1:0] id;
    int v0;
    do_reset();
    req_addr[1*AW +: AW] = 12'd120;
    req = 4'b0010;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clock);
      if (gnt !== '0) got = 1'b1;
    end
    checks++; if (!got || gnt !== 4'b0010) begin errors++; $display("FAIL abort_gnt: got %b expected 0010", gnt); end
    req = '0;
    repeat (3) @(negedge clock);
    v0 = n_valid;
    reset = 1'b1;
    @(negedge clock);
    checks++; if (gnt !== '0 || rd_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_ctrl: got gnt %b valid %b busy %b expected 0000 0 0", gnt, rd_valid, busy); end
    checks++; if (rom_address !== '0 || rd_data !== '0 || rd_id !== '0) begin errors++; $display("FAIL abort_data: got addr %h data %h id %0d expected 000 00 0", rom_address, rd_data, rd_id); end
    reset = 1'b0;
    exp_start = 0;
    repeat (15) @(negedge clock);
    checks++; if (n_valid != v0) begin errors++; $display("FAIL abort_no_valid: got %0d pulses expected 0", n_valid - v0); end
    // Pointer must restart at 0: with 1 and 3 pending, 1 wins (a stale pointer of 2 would pick 3)
    req_addr[1*AW +: AW] = 12'd144;
    req_addr[3*AW +: AW] = 12'd48;
    req = 4'b1010;
    collect(got, g, w, a, lat, d, id);
    checks++; if (g !== 4'b0010 || d !== 8'h48 || id !== 2'd1) begin errors++; $display("FAIL abort_ptr: got %b/%h/id %0d expected 0010/48/id 1", g, d, id); end
    collect(got, g, w, a, lat, d, id);
    checks++; if (g !== 4'b1000 || d !== 8'h7C || id !== 2'd3) begin errors++; $display("FAIL abort_next: got %b/%h/id %0d expected 1000/7c/id 3", g, d, id); end
  endtask

`ifdef GLYPH_INV_EN
  task automatic test_reverse_video();
    bit got; logic [NR-1:0] g; int w, lat; logic [RW*AW-1:0] a; logic [RW-1:0] d; logic [IW-1:0] id;
    do_reset();
    req_addr[0 +: AW] = 12'd48;
    req_inv = 4'b0001;
    req = 4'b0001;
    collect(got, g, w, a, lat, d, id);
    checks++; if (d !== 8'h83 || lat != RW + 1) begin errors++; $display("FAIL inv_on: got %h/lat %0d expected 83/lat %0d", d, lat, RW + 1); end
    req_inv = 4'b0000;
    req = 4'b0001;
    collect(got, g, w, a, lat, d, id);
    checks++; if (d !== 8'h7C) begin errors++; $display("FAIL inv_off: got %h expected 7c", d); end
  endtask
`endif

  task automatic test_random();
    bit got; logic [NR-1:0] g; int w, lat; logic [RW*AW-1:0] a; logic [RW-1:0] d; logic [IW-1:0] id;
    logic [NR-1:0] add, saved, inv_now;
    int win, base;
    do_reset();
    inv_now = '0;
    for (int n = 0; n < 24; n++) begin
      add = NR'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req[$urandom_range(0, NR - 1)] = 1'b0;
      if ((req | add) == '0) add[n % NR] = 1'b1;
      for (int i = 0; i < NR; i++) begin
        if (!req[i] && add[i]) begin
          req_addr[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'(4096 - $urandom_range(1, 8))
                                                             : AW'($urandom_range(0, 4095));
          req[i] = 1'b1;
        end
      end
`ifdef GLYPH_INV_EN
      req_inv = NR'($urandom);
      inv_now = req_inv;
`endif
      if ($urandom_range(0, 3) == 0) begin
        saved = req;
        req = '0;
        repeat ($urandom_range(1, 4)) @(negedge clock);
        req = saved;
      end
      win = pick(req, exp_start);
      base = int'(req_addr[win*AW +: AW]);
      collect(got, g, w, a, lat, d, id);
      checks++; if (g !== NR'(1 << win) || w != 1) begin errors++; $display("FAIL rand%0d_gnt: got %b after %0d expected %b after 1", n, g, w, NR'(1 << win)); end
      checks++; if (a !== exp_addrs(base)) begin errors++; $display("FAIL rand%0d_addrs: got %h expected %h", n, a, exp_addrs(base)); end
      checks++; if (d !== exp_row(base, inv_now[win]) || id !== IW'(win) || lat != RW + 1) begin
        errors++;
        $display("FAIL rand%0d_result: got %h/id %0d/lat %0d expected %h/id %0d/lat %0d",
                 n, d, id, lat, exp_row(base, inv_now[win]), win, RW + 1);
      end
      exp_start = (win + 1) % NR;
    end
    req = '0;
    repeat (4) @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    req_addr = '0;
`ifdef GLYPH_INV_EN
    req_inv = '0;
`endif
    for (int i = 0; i < 4096; i++) rom[i] = bit'($urandom_range(0, 1));
    for (int i = 0; i < 8; i++) begin
      rom[i] = 1'b0;
      rom[4088 + i] = 1'b0;
    end
    begin
      bit [7:0] p48, p120, p144;
      p48 = 8'h7C; p120 = 8'h7E; p144 = 8'h48;
      for (int k = 0; k < 8; k++) begin
        rom[48 + k]  = p48[7 - k];
        rom[120 + k] = p120[7 - k];
        rom[144 + k] = p144[7 - k];
      end
    end
    test_reset();
    test_single();
    test_round_robin();
    test_busy_ignored();
    test_wrap();
    test_reset_abort();
`ifdef GLYPH_INV_EN
    test_reverse_video();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
